// File: rtl/register_unit.sv
// -----------------------------------------------------------------------------
// register_unit
// Architectural register file for the single-cycle RV32I core (x0..x31).
//
// Ports:
//   clk        - single clock, all state updates on its rising edge
//   rst        - synchronous, active-high reset (x2 <- SP_INIT, others <- 0)
//   rs1, rs2   - combinational read addresses for the execute stage
//   rd         - write address
//   ru_wr      - write enable
//   ru_wrdata  - write data from the write-back mux
//   ru_rs1     - contents of register rs1
//   ru_rs2     - contents of register rs2
//   dbg_addr   - debug read address
//   dbg_data   - contents of register dbg_addr
//
// Parameters:
//   SP_INIT    - reset value of x2 (stack pointer)
//   BYPASS     - when 1, a read of the register being written this cycle
//                returns ru_wrdata instead of the stored value
// -----------------------------------------------------------------------------
module register_unit #(
  parameter logic [31:0] SP_INIT = 32'h0000_03FC,
  parameter bit          BYPASS  = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4:0]         rs1,
  input  logic [4:0]         rs2,
  input  logic [4:0]         rd,
  input  logic               ru_wr,
  input  logic signed [31:0] ru_wrdata,
  output logic signed [31:0] ru_rs1,
  output logic signed [31:0] ru_rs2,
  input  logic [4:0]         dbg_addr,
  output logic signed [31:0] dbg_data
);

  // Only x1..x31 have storage; x0 is hard-wired to zero on the read side.
  logic [31:0] r_regs [1:31];

  // Full 32-entry read view with x0 forced to zero, so each read port is a
  // plain index without a special case for address 0.
  logic [31:0] w_view [0:31];

  // A write is only real when enabled and not aimed at x0.
  logic w_wrValid;

  assign w_wrValid = ru_wr && (rd != 5'd0);

  // Storage update: reset wins over a simultaneous write, so the write is
  // simply not considered when rst is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) begin
        r_regs[i] <= (i == 2) ? SP_INIT : 32'h0000_0000;
      end
    end else if (w_wrValid) begin
      r_regs[rd] <= ru_wrdata;
    end
  end

  always_comb begin
    w_view[0] = 32'h0000_0000;
    for (int i = 1; i < 32; i++) begin
      w_view[i] = r_regs[i];
    end
  end

  // Read ports. With BYPASS the in-flight write data is forwarded to any
  // port addressing the write target; x0 is never forwarded because
  // w_wrValid excludes rd == 0.
  always_comb begin
    ru_rs1 = w_view[rs1];
    if (BYPASS && w_wrValid && (rd == rs1)) begin
      ru_rs1 = ru_wrdata;
    end
  end

  always_comb begin
    ru_rs2 = w_view[rs2];
    if (BYPASS && w_wrValid && (rd == rs2)) begin
      ru_rs2 = ru_wrdata;
    end
  end

  always_comb begin
    dbg_data = w_view[dbg_addr];
    if (BYPASS && w_wrValid && (rd == dbg_addr)) begin
      dbg_data = ru_wrdata;
    end
  end

endmodule

// File: tb/tb_register_unit.sv
// -----------------------------------------------------------------------------
// tb_register_unit
// Directed testbench for register_unit. Two instances share all inputs:
// dutA uses BYPASS=0, dutB uses BYPASS=1. Inputs change 1 time unit after
// the rising edge and outputs are sampled well before the next edge.
// -----------------------------------------------------------------------------
module tb_register_unit;

  localparam logic [31:0] SP_INIT = 32'h0000_03FC;

  logic               clk;
  logic               rst;
  logic [4:0]         rs1;
  logic [4:0]         rs2;
  logic [4:0]         rd;
  logic               ru_wr;
  logic signed [31:0] ru_wrdata;
  logic [4:0]         dbg_addr;
  logic signed [31:0] aRs1, aRs2, aDbg;
  logic signed [31:0] bRs1, bRs2, bDbg;

  int checks;
  int errors;

  register_unit #(.SP_INIT(SP_INIT), .BYPASS(1'b0)) dutA (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rd(rd), .ru_wr(ru_wr),
    .ru_wrdata(ru_wrdata), .ru_rs1(aRs1), .ru_rs2(aRs2),
    .dbg_addr(dbg_addr), .dbg_data(aDbg)
  );

  register_unit #(.SP_INIT(SP_INIT), .BYPASS(1'b1)) dutB (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rd(rd), .ru_wr(ru_wr),
    .ru_wrdata(ru_wrdata), .ru_rs1(bRs1), .ru_rs2(bRs2),
    .dbg_addr(dbg_addr), .dbg_data(bDbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge and let inputs settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setRead(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
    rs1 = a1;
    rs2 = a2;
    dbg_addr = ad;
    #1;
  endtask

  task automatic doWrite(input logic [4:0] addr, input logic [31:0] data);
    rd = addr;
    ru_wrdata = data;
    ru_wr = 1'b1;
    tick();
    ru_wr = 1'b0;
  endtask

  // x0 must read zero even before the first reset.
  task automatic test_x0_before_reset();
    setRead(5'd0, 5'd0, 5'd0);
    checks++;
    if (aRs1 !== 32'h0 || aRs2 !== 32'h0 || aDbg !== 32'h0 || bRs1 !== 32'h0) begin
      errors++;
      $display("[TB] FAIL x0_pre_reset: got %h/%h/%h/%h expected 00000000", aRs1, aRs2, aDbg, bRs1);
    end
  endtask

  task automatic test_reset();
    logic [31:0] expVal;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      setRead(a[4:0], a[4:0], a[4:0]);
      expVal = (a == 2) ? SP_INIT : 32'h0;
      checks++;
      if (aRs1 !== expVal || aRs2 !== expVal || aDbg !== expVal ||
          bRs1 !== expVal || bRs2 !== expVal || bDbg !== expVal) begin
        errors++;
        $display("[TB] FAIL reset_x%0d: got %h/%h/%h/%h/%h/%h expected %h",
                 a, aRs1, aRs2, aDbg, bRs1, bRs2, bDbg, expVal);
      end
    end
  endtask

  task automatic test_write_read();
    doWrite(5'd5, 32'h0000_002A);
    doWrite(5'd6, 32'hFFFF_FFF0);
    setRead(5'd5, 5'd6, 5'd6);
    checks++;
    if (aRs1 !== 32'h0000_002A || bRs1 !== 32'h0000_002A) begin
      errors++;
      $display("[TB] FAIL write_read_rs1: got %h/%h expected 0000002a", aRs1, bRs1);
    end
    checks++;
    if (aRs2 !== 32'hFFFF_FFF0 || aDbg !== 32'hFFFF_FFF0 || bRs2 !== 32'hFFFF_FFF0) begin
      errors++;
      $display("[TB] FAIL write_read_rs2: got %h/%h/%h expected fffffff0", aRs2, aDbg, bRs2);
    end
  endtask

  task automatic test_x0_immutable();
    // Write to x0 while reading it: no bypass may leak into x0 either.
    rd = 5'd0;
    ru_wrdata = 32'hDEAD_BEEF;
    ru_wr = 1'b1;
    setRead(5'd0, 5'd0, 5'd0);
    checks++;
    if (bRs1 !== 32'h0 || bDbg !== 32'h0) begin
      errors++;
      $display("[TB] FAIL x0_no_bypass: got %h/%h expected 00000000", bRs1, bDbg);
    end
    tick();
    ru_wr = 1'b0;
    setRead(5'd0, 5'd0, 5'd0);
    checks++;
    if (aRs1 !== 32'h0 || aRs2 !== 32'h0 || aDbg !== 32'h0 || bRs1 !== 32'h0) begin
      errors++;
      $display("[TB] FAIL x0_after_write: got %h/%h/%h/%h expected 00000000", aRs1, aRs2, aDbg, bRs1);
    end
    // Disabled write must not touch x7 (still zero from reset).
    rd = 5'd7;
    ru_wrdata = 32'h1234_5678;
    ru_wr = 1'b0;
    tick();
    setRead(5'd7, 5'd7, 5'd7);
    checks++;
    if (aRs1 !== 32'h0 || aDbg !== 32'h0 || bRs1 !== 32'h0) begin
      errors++;
      $display("[TB] FAIL wr_disabled_x7: got %h/%h/%h expected 00000000", aRs1, aDbg, bRs1);
    end
  endtask

  task automatic test_bypass();
    doWrite(5'd10, 32'h0000_0100);
    rd = 5'd10;
    ru_wrdata = 32'h0000_0104;
    ru_wr = 1'b1;
    setRead(5'd10, 5'd10, 5'd10);
    checks++;
    if (aRs1 !== 32'h0000_0100 || aRs2 !== 32'h0000_0100 || aDbg !== 32'h0000_0100) begin
      errors++;
      $display("[TB] FAIL nobypass_before_edge: got %h/%h/%h expected 00000100", aRs1, aRs2, aDbg);
    end
    checks++;
    if (bRs1 !== 32'h0000_0104 || bRs2 !== 32'h0000_0104 || bDbg !== 32'h0000_0104) begin
      errors++;
      $display("[TB] FAIL bypass_before_edge: got %h/%h/%h expected 00000104", bRs1, bRs2, bDbg);
    end
    // Unrelated port must still see its stored value under bypass.
    setRead(5'd10, 5'd5, 5'd10);
    checks++;
    if (bRs2 !== 32'h0000_002A) begin
      errors++;
      $display("[TB] FAIL bypass_other_port: got %h expected 0000002a", bRs2);
    end
    tick();
    ru_wr = 1'b0;
    setRead(5'd10, 5'd10, 5'd10);
    checks++;
    if (aRs1 !== 32'h0000_0104 || bRs1 !== 32'h0000_0104) begin
      errors++;
      $display("[TB] FAIL after_edge_x10: got %h/%h expected 00000104", aRs1, bRs1);
    end
  endtask

  task automatic test_back_to_back();
    rd = 5'd12;
    ru_wr = 1'b1;
    ru_wrdata = 32'h0000_0001;
    tick();
    setRead(5'd12, 5'd12, 5'd12);
    checks++;
    if (aRs1 !== 32'h0000_0001) begin
      errors++;
      $display("[TB] FAIL b2b_first: got %h expected 00000001", aRs1);
    end
    ru_wrdata = 32'h8000_0002;
    tick();
    ru_wr = 1'b0;
    setRead(5'd12, 5'd12, 5'd12);
    checks++;
    if (aRs1 !== 32'h8000_0002 || bDbg !== 32'h8000_0002) begin
      errors++;
      $display("[TB] FAIL b2b_last_wins: got %h/%h expected 80000002", aRs1, bDbg);
    end
  endtask

  task automatic test_reset_collision();
    rst = 1'b1;
    rd = 5'd2;
    ru_wrdata = 32'h7FFF_FFFF;
    ru_wr = 1'b1;
    tick();
    // Write on the cycle reset deasserts goes through normally.
    rst = 1'b0;
    rd = 5'd3;
    ru_wrdata = 32'h0000_0055;
    tick();
    ru_wr = 1'b0;
    setRead(5'd2, 5'd2, 5'd2);
    checks++;
    if (aRs1 !== SP_INIT || bRs2 !== SP_INIT || aDbg !== SP_INIT) begin
      errors++;
      $display("[TB] FAIL reset_beats_write: got %h/%h/%h expected %h", aRs1, bRs2, aDbg, SP_INIT);
    end
    setRead(5'd5, 5'd12, 5'd3);
    checks++;
    if (aRs1 !== 32'h0 || aRs2 !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_midop_clear: got %h/%h expected 00000000", aRs1, aRs2);
    end
    checks++;
    if (aDbg !== 32'h0000_0055 || bDbg !== 32'h0000_0055) begin
      errors++;
      $display("[TB] FAIL write_after_reset: got %h/%h expected 00000055", aDbg, bDbg);
    end
  endtask

  task automatic test_sweep();
    logic [31:0] expVal;
    for (int a = 1; a < 32; a++) begin
      doWrite(a[4:0], a * 32'h0101_0101);
    end
    doWrite(5'd31, 32'h0);
    for (int a = 0; a < 32; a++) begin
      setRead(a[4:0], a[4:0], a[4:0]);
      expVal = (a == 31) ? 32'h0 : a * 32'h0101_0101;
      checks++;
      if (aRs1 !== expVal || aRs2 !== expVal || aDbg !== expVal ||
          bRs1 !== expVal || bRs2 !== expVal || bDbg !== expVal) begin
        errors++;
        $display("[TB] FAIL sweep_x%0d: got %h/%h/%h/%h/%h/%h expected %h",
                 a, aRs1, aRs2, aDbg, bRs1, bRs2, bDbg, expVal);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    rs1 = 5'd0;
    rs2 = 5'd0;
    rd = 5'd0;
    ru_wr = 1'b0;
    ru_wrdata = 32'h0;
    dbg_addr = 5'd0;
    #2;
    test_x0_before_reset();
    #1;
    rst = 1'b1;
    tick();
    test_reset();
    test_write_read();
    test_x0_immutable();
    test_bypass();
    test_back_to_back();
    test_reset_collision();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_unit.md
# register_unit

Architectural register file for the single-cycle RV32I core. It holds x0–x31 and serves two combinational read ports (rs1, rs2) to the ALU and branch logic, plus one debug read port. It accepts one clocked write per cycle from the write-back source mux: ALU result, data-memory read, or PC+4 adder. It is the consuming end of the `ru_wrdata` path, and its read ports close the datapath loop back into the execute stage.

## Interface
- `SP_INIT`, default `32'h0000_03FC`: value loaded into x2 (sp) on reset.
- `BYPASS`, default `0`: when `1`, a read of the register being written in the same cycle returns `ru_wrdata` instead of the stored value.
- `clk` input, 1 bit: single clock; all state updates occur on its rising edge.
- `rst` input, 1 bit: reset, synchronous, active-high.
- `rs1` input, 5 bits: read address, port 1.
- `rs2` input, 5 bits: read address, port 2.
- `rd` input, 5 bits: write address.
- `ru_wr` input, 1 bit: write enable.
- `ru_wrdata` input, 32 bits signed: write data from the write-back mux.
- `ru_rs1` output, 32 bits signed: contents of register `rs1`.
- `ru_rs2` output, 32 bits signed: contents of register `rs2`.
- `dbg_addr` input, 5 bits: debug read address.
- `dbg_data` output, 32 bits signed: contents of register `dbg_addr`.

## Operation
**Storage**
- 31 physical 32-bit registers, x1–x31.
- x0 has no storage: every read of address 0 returns `32'h0000_0000` on every port.

**Write**
- On a rising `clk` with `rst`=0, `ru_wr`=1 and `rd`≠0, register[`rd`] ← `ru_wrdata`.
- All other registers hold.

**Ignored writes**
- `ru_wr`=1 with `rd`=0 is discarded silently.
- `ru_wr`=0 leaves all state unchanged, whatever `rd` or `ru_wrdata` are.

**Reads**
- All three read ports are purely combinational from the current register state and their address inputs.
- No read enable is needed.

**Bypass (`BYPASS`=1 only)**
- If `ru_wr`=1, `rd`≠0 and `rd` equals `rs1`, `rs2` or `dbg_addr`, that port outputs `ru_wrdata` combinationally.
- With `BYPASS`=0 the port outputs the stored (old) value until the edge.

**Reset**
- Synchronous: on a rising `clk` with `rst`=1, x1 and x3–x31 ← 0 and x2 ← `SP_INIT`.
- Reset has priority over a simultaneous write; that write is lost.
- A write asserted on the cycle `rst` deasserts is performed normally.

**Reset values seen on outputs**
- After the reset edge, `ru_rs1`, `ru_rs2` and `dbg_data` read 0, except when addressing x2, which reads `SP_INIT`.
- Before the first reset edge, register contents are undefined (X in simulation). The x0 reads are the exception and are always 0.

**Data width**
- Data passes through unmodified: no sign or zero extension and no truncation.
- `signed` affects interpretation only.

## Timing
**Read latency**
- 0 cycles, combinational from `rs1`/`rs2`/`dbg_addr` and the current state.

**Write latency**
- 1 edge: a value written at edge N is visible on the read ports immediately after edge N.
- With `BYPASS`=1, the value is visible before edge N, during the write cycle.

**Back-to-back writes**
- Consecutive writes to the same `rd` each take effect at their own edge; the last one wins.

**Reset mid-operation**
- `rst` asserted for one cycle at any point restores the full reset state at that edge.
- The next cycle behaves normally.

**No multi-cycle operations**
- There is no handshake and no stall input; a write completes every cycle in which it is enabled.

## Test plan
- **Reset values:** `rst`=1 for one edge, then read all 32 addresses on `rs1`, `rs2` and `dbg_addr` → x2 = `32'h0000_03FC`, every other address = 0.
- **Write then read:** write x5 = `32'h0000_002A`, then x6 = `32'hFFFF_FFF0` (`ru_wr`=1); read `rs1`=5, `rs2`=6 → `ru_rs1` = `0x0000_002A`, `ru_rs2` = `0xFFFF_FFF0`.
- **x0 immutability:** `ru_wr`=1, `rd`=0, `ru_wrdata` = `32'hDEAD_BEEF` for one edge → `rs1`=0 reads 0. Also `ru_wr`=0, `rd`=7, data = `0x1234_5678` → x7 is unchanged.
- **Same-cycle read of write target (`BYPASS`=0):** x10 holds `0x0000_0100`; drive `ru_wr`=1, `rd`=10, `ru_wrdata` = `0x0000_0104`, `rs1`=10:
  - before the edge, `ru_rs1` = `0x0000_0100`;
  - after the edge, `ru_rs1` = `0x0000_0104`.
  - With `BYPASS`=1, `ru_rs1` = `0x0000_0104` before the edge.
- **Reset vs. write collision:** `rst`=1 together with `ru_wr`=1, `rd`=2, data = `0x7FFF_FFFF` → after the edge, x2 = `0x0000_03FC`.
- **Overwrite and all-register sweep:**
  - write x1–x31 with value = address × `0x0101_0101`, then overwrite x31 with 0 on the next edge;
  - → x31 = 0 and every other register holds its sweep value on all three read ports.
